// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Arbitrates an instruction-fetch port and a data port onto one
//            shared memory port. Data wins by default; the selected request
//            is latched at grant so the shared port is unaffected by
//            requester changes while a transaction is in flight.
// Ports    : clk, rst (async, active high)
//            imem_read/imem_addr -> imem_rdata/imem_resp       fetch side
//            dmem_read/dmem_write/dmem_addr/dmem_wdata/
//            dmem_byte_enable    -> dmem_rdata/dmem_resp       data side
//            mem_read/mem_write/mem_address/mem_wdata/
//            mem_byte_enable     <- mem_rdata/mem_resp         shared port
//            busy                                              txn outstanding
// Config   : MEM_ARB_STARVE_GUARD_EN enables the fetch starvation guard;
//            STARVE_LIMIT sets how many data grants fetch may wait through.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        imem_read,
    input  logic [31:0] imem_addr,
    output logic [31:0] imem_rdata,
    output logic        imem_resp,
    input  logic        dmem_read,
    input  logic        dmem_write,
    input  logic [31:0] dmem_addr,
    input  logic [31:0] dmem_wdata,
    input  logic [3:0]  dmem_byte_enable,
    output logic [31:0] dmem_rdata,
    output logic        dmem_resp,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_address,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_byte_enable,
    input  logic [31:0] mem_rdata,
    input  logic        mem_resp,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DATA  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic        w_grant_data;
    logic        w_grant_fetch;
    logic        w_fetch_first;

    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_be;
    logic        r_write;

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam int C_CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [C_CW-1:0] C_LIMIT = C_CW'(STARVE_LIMIT);

    logic [C_CW-1:0] r_starve_cnt;

    // Once fetch has waited through STARVE_LIMIT data grants it takes the next slot.
    assign w_fetch_first = (r_starve_cnt == C_LIMIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_starve_cnt <= '0;
        end else if (w_grant_fetch) begin
            r_starve_cnt <= '0;
        end else if (w_grant_data && imem_read && (r_starve_cnt != C_LIMIT)) begin
            r_starve_cnt <= r_starve_cnt + 1'b1;
        end
    end
`else
    logic w_unused_starve_limit;
    assign w_unused_starve_limit = (STARVE_LIMIT > 0);
    assign w_fetch_first         = 1'b0;
`endif

    // Grants are only made from IDLE, which also enforces the idle gap
    // between back-to-back transactions.
    always_comb begin
        w_grant_data  = 1'b0;
        w_grant_fetch = 1'b0;
        w_next        = r_state;
        case (r_state)
            S_IDLE: begin
                w_grant_data  = (dmem_read | dmem_write) & ~(imem_read & w_fetch_first);
                w_grant_fetch = imem_read & ~w_grant_data;
                if (w_grant_data) begin
                    w_next = S_DATA;
                end else if (w_grant_fetch) begin
                    w_next = S_FETCH;
                end
            end
            S_FETCH: if (mem_resp) w_next = S_IDLE;
            S_DATA:  if (mem_resp) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Request capture. A simultaneous read+write is treated as a write;
    // reads always use all byte lanes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr  <= '0;
            r_wdata <= '0;
            r_be    <= '0;
            r_write <= 1'b0;
        end else if (w_grant_data) begin
            r_addr  <= dmem_addr;
            r_wdata <= dmem_wdata;
            r_be    <= dmem_write ? dmem_byte_enable : 4'hF;
            r_write <= dmem_write;
        end else if (w_grant_fetch) begin
            r_addr  <= imem_addr;
            r_wdata <= '0;
            r_be    <= 4'hF;
            r_write <= 1'b0;
        end
    end

    assign busy            = (r_state != S_IDLE);
    assign mem_read        = busy & ~r_write;
    assign mem_write       = (r_state == S_DATA) & r_write;
    assign mem_address     = r_addr;
    assign mem_wdata       = r_wdata;
    assign mem_byte_enable = r_be;

    // Responses are only forwarded while a transaction is owned; a stray
    // mem_resp in IDLE (e.g. after a reset abort) is dropped.
    assign imem_resp  = (r_state == S_FETCH) & mem_resp;
    assign dmem_resp  = (r_state == S_DATA)  & mem_resp;
    assign imem_rdata = mem_rdata;
    assign dmem_rdata = mem_rdata;

endmodule
`default_nettype wire
